// File: rtl/pc_pkg.sv
// Shared CPU definitions used by the program counter and its next-value logic.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package pc_pkg;

    // Instruction address width of the 16-bit datapath.
    localparam int ADDR_WIDTH = 16;

    // Address the PC returns to on reset.
    localparam logic [ADDR_WIDTH-1:0] PC_RESET_VECTOR = 16'h0000;

    // Which source feeds the PC on the next edge.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        REL  = 2'd2,
        INC  = 2'd3
    } pc_sel_t;

    // Control priority: halt beats absolute load, absolute load beats
    // relative branch, and with nothing asserted the PC steps by one.
    function automatic pc_sel_t pc_decode(
        input logic stahp,
        input logic pcdrive,
        input logic of
    );
        pc_sel_t sel;
        sel = INC;
        if (stahp) begin
            sel = HOLD;
        end else if (pcdrive) begin
            sel = LOAD;
        end else if (of) begin
            sel = REL;
        end
        return sel;
    endfunction

endpackage : pc_pkg

// File: rtl/pc_next_sel.sv
// Next-PC selection: decodes the control levels and forms the candidate PC.
// Latency: purely combinational, zero cycles.
// Backpressure: none; controls are levels consumed every cycle.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH
) (
    input  logic             stahp_i,
    input  logic             pcdrive_i,
    input  logic             of_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] in_i,
    output pc_sel_t          sel_o,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Decode the control levels into a single source selection.
    always_comb begin
        sel_o = INC;
        sel_o = pc_decode(stahp_i, pcdrive_i, of_i);
    end

    // Form the next PC. in_i is only touched on LOAD/REL so an undriven or
    // unknown operand cannot leak into a hold or increment. Additions wrap
    // modulo 2^WIDTH; the carry out is dropped on purpose.
    always_comb begin
        next_o = pc_i;
        unique case (sel_o)
            HOLD:    next_o = pc_i;
            LOAD:    next_o = in_i;
            REL:     next_o = pc_i + in_i;
            INC:     next_o = pc_i + ONE;
            default: next_o = pc_i;
        endcase
    end

endmodule : pc_next_sel

// File: rtl/pc.sv
// Program counter: holds, loads, branches relative, or increments each edge.
// Latency: one cycle from control/in sampling to out; out is register-only.
// Backpressure: none; stahp is a level that freezes the PC while high.
module pc
    import pc_pkg::*;
#(
    parameter int               WIDTH       = ADDR_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = PC_RESET_VECTOR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcdrive,
    input  logic             of,
    input  logic             stahp,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] next_pc;
    pc_sel_t          sel;

    pc_next_sel #(
        .WIDTH (WIDTH)
    ) u_next_sel (
        .stahp_i   (stahp),
        .pcdrive_i (pcdrive),
        .of_i      (of),
        .pc_i      (pc_q),
        .in_i      (in),
        .sel_o     (sel),
        .next_o    (next_pc)
    );

    // Hold is taken straight from the register so a halted PC never depends
    // on the adder path at all.
    always_comb begin
        pc_d = next_pc;
        if (sel == HOLD) begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous reset; reset discards any pending operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign out = pc_q;

    // One edge after reset is sampled, the PC sits at the reset vector.
    a_reset_value: assert property (@(posedge clk) reset |=> (out == RESET_VALUE))
        else $error("pc: out not at reset value after reset");

    // A halted PC does not move (reset still takes precedence over halt).
    a_stahp_stable: assert property (@(posedge clk) (stahp && !reset) |=> $stable(out))
        else $error("pc: out changed while halted");

endmodule : pc

// File: tb/tb_pc.sv
// Directed bench for the program counter with hand-computed expectations.
// Latency: checks out 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pc;

    logic        clk;
    logic        reset;
    logic        pcdrive;
    logic        of;
    logic        stahp;
    logic [15:0] din;
    logic [15:0] dout;

    int n_cmp;
    int n_bad;

    logic [15:0] last_exp;
    logic        have_last;

    pc #(
        .WIDTH       (16),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pcdrive (pcdrive),
        .of      (of),
        .stahp   (stahp),
        .in      (din),
        .out     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of controls, confirm out did not react combinationally,
    // then clock once and compare out with the expected value.
    task automatic step(
        input logic        r,
        input logic        s,
        input logic        p,
        input logic        o,
        input logic [15:0] i,
        input logic [15:0] exp,
        input string       tag
    );
        reset   = r;
        stahp   = s;
        pcdrive = p;
        of      = o;
        din     = i;
        #1;
        if (have_last) begin
            n_cmp++;
            assert (dout === last_exp) else begin
                n_bad++;
                $error("FAIL %s/comb: out=%h expected=%h", tag, dout, last_exp);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        assert (dout === exp) else begin
            n_bad++;
            $error("FAIL %s: out=%h expected=%h", tag, dout, exp);
        end
        last_exp  = exp;
        have_last = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        have_last = 1'b0;
        last_exp  = 16'h0000;
        reset     = 1'b0;
        stahp     = 1'b0;
        pcdrive   = 1'b0;
        of        = 1'b0;
        din       = 16'h0000;
        @(negedge clk);

        //    r     s     p     o     in        expected
        // Reset held over a competing load
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h0000, "reset_1");
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h0000, "reset_2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, "post_reset_inc1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, "post_reset_inc2");

        // Absolute load then increment
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'hA1A1, 16'hA1A1, "load");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hA1A2, "load_inc");

        // Increment with unknown in must not be disturbed by in
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'hxxxx, 16'hA1A3, "inc_in_x");

        // Relative branches forward and backward
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h1000, "load_1000");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h1010, "rel_fwd");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFF0, 16'h1000, "rel_back");

        // Wrap-around on increment and on offset add
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, "load_ffff");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, "inc_wrap");
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, "load_fffe");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0002, "rel_wrap");

        // Priority: halt over load, load over relative, reset over halt
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234, "load_1234");
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234, "stahp_over_load");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h1234, "stahp_over_rel");
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hxxxx, 16'h1234, "stahp_in_x");
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0040, "load_over_rel");
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000, "reset_over_stahp");

        // Reset in the middle of an increment run
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, "run_1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, "run_2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, "run_3");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, "run_4");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, "run_5");
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000, "mid_reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, "after_mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pc

// File: doc/pc.md
# pc

Program counter register for the 16-bit CPU datapath. Holds the current instruction address on `out`. Each clock it either holds, loads an absolute address, adds a signed relative offset, or increments by one. Sits between the control unit, which drives `pcdrive`, `of` and `stahp`, and the instruction-fetch address path.

## Interface
- `WIDTH`, 16: address width in bits.
- `RESET_VALUE`, 16'h0000: value loaded on reset.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `pcdrive`  input  1  absolute load: next PC = `in`.
- `of`  input  1  relative branch: next PC = PC + `in`, with `in` treated as two's-complement.
- `stahp`  input  1  halt: PC holds its value.
- `in`  input  WIDTH  load address or signed offset.
- `out`  output  WIDTH  current PC, driven directly from the register.

## Operation
- Single WIDTH-bit register `pc_q`; `out = pc_q`.
- Next-value priority, evaluated every rising edge:
  1. `reset`=1: `pc_q <= RESET_VALUE`.
  2. `stahp`=1: `pc_q <= pc_q`.
  3. `pcdrive`=1: `pc_q <= in`.
  4. `of`=1: `pc_q <= pc_q + in`, modulo 2^WIDTH.
  5. Otherwise: `pc_q <= pc_q + 1`, modulo 2^WIDTH.
- `pcdrive` and `of` both high: `pcdrive` wins and the offset is ignored.
- `stahp` overrides every control except `reset`.
- Wrap-around:
  - 16'hFFFF + 1 gives 16'h0000.
  - Offset addition discards the carry; no overflow flag is produced.
- `in` is ignored when neither `pcdrive` nor `of` is selected; X on `in` must not propagate in that case.
- No internal state exists besides `pc_q`.

## Timing
- Latency is one cycle: controls and `in` are sampled at edge N, and `out` shows the result after edge N.
- `out` is purely registered, with no combinational path from any input.
- Reset is synchronous:
  - Asserting `reset` has no effect until the next rising edge.
  - While `reset` is held, `out` stays RESET_VALUE every cycle.
  - On the first edge after `reset` deasserts, normal priority applies.
- Before the first reset edge, `out` is undefined; the bench must not check it.
- Reset in the middle of any operation discards that operation.
- No handshake exists; every control is a level sampled each edge.

## Structure
- Shared CPU package holds:
  - `ADDR_WIDTH` = 16.
  - `PC_RESET_VECTOR` = 16'h0000.
  - A `pc_sel_t` enum: HOLD, LOAD, REL, INC.
- Optional combinational sub-module `pc_next_sel`:
  - Inputs: controls, `pc_q`, `in`.
  - Outputs: the `pc_sel_t` selection and the next-PC value.
  - Keeps the top module as the register plus the reset mux.
- Include assertions:
  - `out` equals RESET_VALUE one edge after `reset`.
  - `out` is stable while `stahp`=1.

## Test plan
- Reset: `reset`=1 for 2 edges with `pcdrive`=1, `in`=16'hAAAA -> `out`=16'h0000 after each edge. Then release `reset` with all controls 0 -> 16'h0001, 16'h0002 on the next edges.
- Load: `pcdrive`=1, `in`=16'hA1A1 -> `out`=16'hA1A1 after one edge. Then controls 0 -> 16'hA1A2.
- Relative branch:
  - From 16'h1000, `of`=1, `in`=16'h0010 -> 16'h1010.
  - Then `in`=16'hFFF0 (−16) -> 16'h1000.
- Wrap: load 16'hFFFF, then increment -> 16'h0000. Load 16'hFFFE, `of`=1, `in`=16'h0004 -> 16'h0002.
- Priority:
  - From 16'h1234, `stahp`=1 with `pcdrive`=1, `in`=16'h0000 -> stays 16'h1234.
  - `pcdrive`=1 and `of`=1 with `in`=16'h0040 -> 16'h0040.
  - `reset`=1 with `stahp`=1 -> 16'h0000.
- Reset mid-run: increment for 5 cycles from 0, then assert `reset` for one edge -> 16'h0000. Next edge with controls 0 -> 16'h0001.
